// File: rtl/dc_ac_probe_pkg.sv
// Shared constants for the DC+AC probe: 16-point cosine reference, sine phase offset,
// FSM states and the accumulator-width rule.
package dc_ac_probe_pkg;

  localparam int COEF_WIDTH = 12;
  localparam int LUT_N      = 16;
  localparam int SIN_OFFSET = 4;

  // round(2047*cos(2*pi*p/16)); sin[p] is read as cos[(p-4) mod 16]
  localparam logic signed [COEF_WIDTH-1:0] COS_LUT [LUT_N] = '{
     12'sd2047,  12'sd1891,  12'sd1447,  12'sd783,
     12'sd0,    -12'sd783,  -12'sd1447, -12'sd1891,
    -12'sd2047, -12'sd1891, -12'sd1447, -12'sd783,
     12'sd0,     12'sd783,   12'sd1447,  12'sd1891
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int acc_width(input int sample_w, input int coef_w, input int n_samples);
    return sample_w + coef_w + $clog2(n_samples) + 1;
  endfunction

endpackage

// File: rtl/dc_ac_probe_mac.sv
// One correlation lane: stage 1 registers the full-width signed product,
// stage 2 sign-extends it into the running accumulator.
module dc_ac_probe_mac #(
  parameter int SAMPLE_W = 16,
  parameter int COEF_W   = 12,
  parameter int ACC_W    = 35
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_en,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic signed [COEF_W-1:0]   i_coef,
  output logic signed [ACC_W-1:0]    o_acc
);

  localparam int PROD_W = SAMPLE_W + COEF_W;

  logic signed [PROD_W-1:0] w_sample_ext;
  logic signed [PROD_W-1:0] w_coef_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [PROD_W-1:0] r_prod;
  logic                     r_vld;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_sample_ext = {{COEF_W{i_sample[SAMPLE_W-1]}}, i_sample};
  assign w_coef_ext   = {{SAMPLE_W{i_coef[COEF_W-1]}}, i_coef};
  assign w_prod       = w_sample_ext * w_coef_ext;
  assign w_prod_ext   = {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};

  // Two-stage multiply-accumulate; clear also squashes an in-flight product
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_prod <= '0;
      r_vld  <= 1'b0;
      r_acc  <= '0;
    end else begin
      r_vld <= i_en;
      if (i_en) begin
        r_prod <= w_prod;
      end else begin
        r_prod <= r_prod;
      end
      if (r_vld) begin
        r_acc <= r_acc + w_prod_ext;
      end else begin
        r_acc <= r_acc;
      end
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/dc_ac_probe.sv
// DC + I/Q correlation probe: integrates CYCLES periods of 16 samples and reports
// the sample sum and its correlation against fixed cosine/sine references.
module dc_ac_probe
  import dc_ac_probe_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int COEF_W   = COEF_WIDTH,
  parameter int PERIOD   = LUT_N,
  parameter int CYCLES   = 4,
  parameter int ACC_W    = acc_width(SAMPLE_W, COEF_W, PERIOD * CYCLES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  input  logic                       s_valid,
  input  logic signed [SAMPLE_W-1:0] s_data,
  output logic                       dropped,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [ACC_W-1:0]    res_dc,
  output logic signed [ACC_W-1:0]    res_i,
  output logic signed [ACC_W-1:0]    res_q
);

  localparam int                N_SAMP  = PERIOD * CYCLES;
  localparam int                K_W     = $clog2(N_SAMP);
  localparam logic [K_W-1:0]    K_LAST  = K_W'(N_SAMP - 1);
  localparam logic [3:0]        SIN_OFS = 4'(SIN_OFFSET);

  state_t                    r_state;
  logic [3:0]                r_phase;
  logic [K_W-1:0]            r_k;
  logic [1:0]                r_flush;
  logic signed [SAMPLE_W-1:0] r_dc_x;
  logic                      r_dc_vld;
  logic signed [ACC_W-1:0]   r_dc_acc;

  logic                      w_clear;
  logic                      w_en;
  logic [3:0]                w_sin_idx;
  logic signed [COEF_W-1:0]  w_cos;
  logic signed [COEF_W-1:0]  w_sin;
  logic signed [ACC_W-1:0]   w_acc_i;
  logic signed [ACC_W-1:0]   w_acc_q;
  logic signed [ACC_W-1:0]   w_dc_ext;

  assign w_clear   = start && ((r_state == S_IDLE) || ((r_state == S_DONE) && res_ready));
  assign w_en      = s_valid && (r_state == S_ACCUM);
  assign w_sin_idx = r_phase - SIN_OFS;
  assign w_cos     = COS_LUT[r_phase];
  assign w_sin     = COS_LUT[w_sin_idx];
  assign w_dc_ext  = {{(ACC_W-SAMPLE_W){r_dc_x[SAMPLE_W-1]}}, r_dc_x};

  dc_ac_probe_mac #(.SAMPLE_W(SAMPLE_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac_i (
    .clk(clk), .rst(rst), .i_clear(w_clear), .i_en(w_en),
    .i_sample(s_data), .i_coef(w_cos), .o_acc(w_acc_i)
  );

  dc_ac_probe_mac #(.SAMPLE_W(SAMPLE_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac_q (
    .clk(clk), .rst(rst), .i_clear(w_clear), .i_en(w_en),
    .i_sample(s_data), .i_coef(w_sin), .o_acc(w_acc_q)
  );

  // DC lane: same two-stage timing as the MAC lanes, without the multiplier
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_dc_x   <= '0;
      r_dc_vld <= 1'b0;
      r_dc_acc <= '0;
    end else begin
      r_dc_vld <= w_en;
      r_dc_x   <= w_en ? s_data : r_dc_x;
      r_dc_acc <= r_dc_vld ? (r_dc_acc + w_dc_ext) : r_dc_acc;
    end
  end

  // Run control; FLUSH spans three edges so results land exactly three cycles after the last sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_phase   <= 4'd0;
      r_k       <= '0;
      r_flush   <= 2'd0;
      busy      <= 1'b0;
      dropped   <= 1'b0;
      res_valid <= 1'b0;
      res_dc    <= '0;
      res_i     <= '0;
      res_q     <= '0;
    end else begin
      dropped <= s_valid && (r_state != S_ACCUM);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ACCUM;
            r_phase <= 4'd0;
            r_k     <= '0;
            busy    <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (s_valid) begin
            r_phase <= r_phase + 4'd1;
            if (r_k == K_LAST) begin
              r_state <= S_FLUSH;
              r_flush <= 2'd0;
            end else begin
              r_k <= r_k + {{(K_W-1){1'b0}}, 1'b1};
            end
          end
        end
        S_FLUSH: begin
          if (r_flush == 2'd2) begin
            res_dc    <= r_dc_acc;
            res_i     <= w_acc_i;
            res_q     <= w_acc_q;
            res_valid <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_flush <= r_flush + 2'd1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (start) begin
              r_state <= S_ACCUM;
              r_phase <= 4'd0;
              r_k     <= '0;
              busy    <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
